// File: rtl/antic_pkg.sv
// Shared ANTIC NMI definitions: register addresses, NMIEN/NMIST bit positions
// and the NMI pulse FSM state type.
package antic_pkg;

   localparam logic [15:0] NMIEN_ADDR = 16'hD40E;
   localparam logic [15:0] NMIST_ADDR = 16'hD40F;

   localparam int BIT_DLI = 7;
   localparam int BIT_VBI = 6;
   localparam int BIT_RST = 5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ASSERT = 2'd1,
      ST_GAP    = 2'd2
   } nmi_state_t;

endpackage

// File: rtl/nmi_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, followed by a rising-edge
// detector. o_rise is high for one clk cycle per synchronized 0->1 transition.
module nmi_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_rise
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= i_async;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/antic_nmi_ctrl.sv
// ANTIC NMI controller: NMIEN/NMIST registers and the fixed-length nmi_n pulse FSM.
// Define NMI_RESET_KEY_EN to add the console RESET key as an NMI source (NMIST[5]).
module antic_nmi_ctrl
   import antic_pkg::*;
#(
   parameter int PULSE_LEN = 4,
   parameter int GAP_LEN   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        CPU_writeEn,
   input  logic [15:0] CPU_addr,
   input  logic [7:0]  CPU_wdata,
   input  logic        dli_evt,
   input  logic        vbi_evt,
   input  logic        reset_key,
   output logic [7:0]  NMIEN,
   output logic [7:0]  NMIST,
   output logic        nmi_n,
   output logic        nmi_busy
);

   localparam logic [3:0] PULSE_LD = 4'(PULSE_LEN - 1);
   localparam logic [3:0] GAP_LD   = 4'(GAP_LEN - 1);

   logic       w_wr_nmien;
   logic       w_wr_nmires;
   logic       w_rk_rise;
   logic       w_req;
   logic       w_unused_bits;

   logic       r_en_dli;
   logic       r_en_vbi;
   logic       r_st_dli;
   logic       r_st_vbi;
   logic       r_st_rst;

   nmi_state_t r_state;
   logic [3:0] r_cnt;
   logic       r_pending;
   logic       r_nmi_n;
   logic       r_busy;

   assign w_wr_nmien  = CPU_writeEn && (CPU_addr == NMIEN_ADDR);
   assign w_wr_nmires = CPU_writeEn && (CPU_addr == NMIST_ADDR);

`ifdef NMI_RESET_KEY_EN
   nmi_sync_edge u_rk_sync (
      .clk     (clk),
      .rst     (rst),
      .i_async (reset_key),
      .o_rise  (w_rk_rise)
   );
   assign w_unused_bits = ^CPU_wdata[5:0];
`else
   assign w_rk_rise     = 1'b0;
   assign w_unused_bits = ^{CPU_wdata[5:0], reset_key};
`endif

   // Enables are the values held before this edge, so a same-edge NMIEN write never gates the event.
   assign w_req = (dli_evt & r_en_dli) | (vbi_evt & r_en_vbi) | w_rk_rise;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_en_dli <= 1'b0;
         r_en_vbi <= 1'b0;
         r_st_dli <= 1'b0;
         r_st_vbi <= 1'b0;
         r_st_rst <= 1'b0;
      end else begin
         if (w_wr_nmien) begin
            r_en_dli <= CPU_wdata[BIT_DLI];
            r_en_vbi <= CPU_wdata[BIT_VBI];
         end
         // A new event wins over a same-edge NMIRES for its own bit.
         r_st_dli <= dli_evt   | (r_st_dli & ~w_wr_nmires);
         r_st_vbi <= vbi_evt   | (r_st_vbi & ~w_wr_nmires);
         r_st_rst <= w_rk_rise | (r_st_rst & ~w_wr_nmires);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= 4'd0;
         r_pending <= 1'b0;
         r_nmi_n   <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req || r_pending) begin
                  r_state   <= ST_ASSERT;
                  r_cnt     <= PULSE_LD;
                  r_pending <= 1'b0;
                  r_nmi_n   <= 1'b0;
                  r_busy    <= 1'b1;
               end
            end
            ST_ASSERT: begin
               if (w_req) begin
                  r_pending <= 1'b1;
               end
               if (r_cnt == 4'd0) begin
                  r_state <= ST_GAP;
                  r_cnt   <= GAP_LD;
                  r_nmi_n <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_GAP: begin
               if (w_req) begin
                  r_pending <= 1'b1;
               end
               if (r_cnt == 4'd0) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= 4'd0;
               r_nmi_n <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      NMIEN          = 8'h00;
      NMIEN[BIT_DLI] = r_en_dli;
      NMIEN[BIT_VBI] = r_en_vbi;
      NMIST          = 8'h1F;
      NMIST[BIT_DLI] = r_st_dli;
      NMIST[BIT_VBI] = r_st_vbi;
      NMIST[BIT_RST] = r_st_rst;
   end

   assign nmi_n    = r_nmi_n;
   assign nmi_busy = r_busy;

endmodule
